// File: rtl/minmax_accumulator_pkg.sv
// Shared types and helpers for the min/max/sum streaming statistics block.
package minmax_accumulator_pkg;

  // Fold-stage state encoding; 2'b11 is unreachable and recovers to ST_EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_TRACK = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  // Saturation point of a cnt_w-bit sample counter.
  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/addern.sv
// n-bit ripple-style adder with carry in and carry out.
module addern #(
  parameter int unsigned n = 8
) (
  input  logic         Cin,
  input  logic [n-1:0] X,
  input  logic [n-1:0] Y,
  output logic [n-1:0] S,
  output logic         Cout
);

  assign {Cout, S} = {1'b0, X} + {1'b0, Y} + {{n{1'b0}}, Cin};

endmodule

// File: rtl/comparison.sv
// Unsigned magnitude comparator.
module comparison #(
  parameter int unsigned n = 4
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         AgtB,
  output logic         AltB
);

  assign AgtB = (A > B);
  assign AltB = (A < B);

endmodule

// File: rtl/minmax_fold_stage.sv
// Stage 2: folds the stage-1 sample into max/min/sum/count and owns the state register.
module minmax_fold_stage
  import minmax_accumulator_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               s1_valid,
  input  logic [N-1:0]       s1_data,
  output logic [N-1:0]       max_val,
  output logic [N-1:0]       min_val,
  output logic [N+CNT_W-1:0] sum_val,
  output logic [CNT_W-1:0]   count_val,
  output state_t             state
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));

  state_t               state_q, state_d;
  logic [N-1:0]         max_q, max_d, min_q, min_d;
  logic [N+CNT_W-1:0]   sum_q, sum_d, sum_add, s1_zext;
  logic [CNT_W-1:0]     count_q, count_d, count_inc;
  logic                 gt_max, lt_min;
  logic                 unused_sum_cout, unused_cnt_cout;

  assign s1_zext = {{CNT_W{1'b0}}, s1_data};

  comparison #(.n(N)) u_cmp_max (
    .A    (s1_data),
    .B    (max_q),
    .AgtB (gt_max),
    .AltB ()
  );

  comparison #(.n(N)) u_cmp_min (
    .A    (s1_data),
    .B    (min_q),
    .AgtB (),
    .AltB (lt_min)
  );

  addern #(.n(N + CNT_W)) u_sum_add (
    .Cin  (1'b0),
    .X    (sum_q),
    .Y    (s1_zext),
    .S    (sum_add),
    .Cout (unused_sum_cout)
  );

  // Counter incrementer: count + 0 + carry-in.
  addern #(.n(CNT_W)) u_cnt_inc (
    .Cin  (1'b1),
    .X    (count_q),
    .Y    ({CNT_W{1'b0}}),
    .S    (count_inc),
    .Cout (unused_cnt_cout)
  );

  // Next-state and fold datapath; clr discards any fold on the same edge.
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    sum_d   = sum_q;
    count_d = count_q;
    if (clr) begin
      state_d = ST_EMPTY;
      max_d   = '0;
      min_d   = '0;
      sum_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (s1_valid) begin
            max_d   = s1_data;
            min_d   = s1_data;
            sum_d   = s1_zext;
            count_d = {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = (CntMax == {{(CNT_W-1){1'b0}}, 1'b1}) ? ST_FULL : ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (s1_valid) begin
            if (gt_max) max_d = s1_data;
            if (lt_min) min_d = s1_data;
            sum_d   = sum_add;
            count_d = count_inc;
            if (count_inc == CntMax) state_d = ST_FULL;
          end
        end
        ST_FULL: ;
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Statistics and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      max_q   <= '0;
      min_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign max_val   = max_q;
  assign min_val   = min_q;
  assign sum_val   = sum_q;
  assign count_val = count_q;
  assign state     = state_q;

endmodule

// File: rtl/minmax_accumulator.sv
// Streaming min/max/sum/count statistics: handshake and stage-1 capture register.
module minmax_accumulator
  import minmax_accumulator_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  output logic [N-1:0]       max_out,
  output logic [N-1:0]       min_out,
  output logic [N+CNT_W-1:0] sum_out,
  output logic [CNT_W-1:0]   count_out,
  output logic               out_valid,
  output logic               full
);

  localparam logic [CNT_W-1:0] CntNearFull = CNT_W'(cnt_max(CNT_W) - 1);

  logic         s1_valid_q;
  logic [N-1:0] s1_data_q;
  logic         accept;
  state_t       state;

  // The last term stops an accept that would overshoot the cap while one sample is in flight.
  assign in_ready = rst_n && !clr && (state != ST_FULL) &&
                    !(s1_valid_q && (count_out == CntNearFull));
  assign accept   = in_valid && in_ready;

  // Stage-1 capture; clears when nothing new is accepted so a held sample is never refolded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else if (clr) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_data_q  <= in_data;
    end else begin
      s1_valid_q <= 1'b0;
    end
  end

  minmax_fold_stage #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_fold (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .s1_valid  (s1_valid_q),
    .s1_data   (s1_data_q),
    .max_val   (max_out),
    .min_val   (min_out),
    .sum_val   (sum_out),
    .count_val (count_out),
    .state     (state)
  );

  assign out_valid = (count_out != '0);
  assign full      = (state == ST_FULL);

endmodule

// File: tb/tb_minmax_accumulator.sv
// Scoreboard bench for minmax_accumulator (N=4, CNT_W=4).
module tb_minmax_accumulator;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_ready, out_valid, full;
  logic [3:0] in_data, max_out, min_out, count_out;
  logic [7:0] sum_out;
  logic [21:0] dut_stat;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [21:0] stat;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  // Reference model of what has been accepted.
  logic [3:0] m_max, m_min;
  logic [7:0] m_sum;
  int         m_acc;

  minmax_accumulator #(.N(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .max_out   (max_out),
    .min_out   (min_out),
    .sum_out   (sum_out),
    .count_out (count_out),
    .out_valid (out_valid),
    .full      (full)
  );

  assign dut_stat = {max_out, min_out, sum_out, count_out, out_valid, full};

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic model_reset();
    m_max = '0; m_min = '0; m_sum = '0; m_acc = 0;
    exp_q.delete();
  endtask

  // Record an accepted sample; its statistics become visible one edge after the accept edge.
  task automatic model_accept(input logic [3:0] x);
    exp_t e;
    if (m_acc == 0) begin
      m_max = x; m_min = x; m_sum = {4'b0, x};
    end else begin
      if (x > m_max) m_max = x;
      if (x < m_min) m_min = x;
      m_sum = m_sum + {4'b0, x};
    end
    m_acc++;
    e.stat = {m_max, m_min, m_sum, m_acc[3:0], 1'b1, (m_acc == 15)};
    e.due  = edge_cnt + 2;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; clr = 1'b0; in_data = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; clr = 1'b0; in_data = 4'd5;
    #2;
    checks++;
    if (dut_stat !== 22'd0) begin
      errors++; $display("FAIL reset_stats got %h exp %h", dut_stat, 22'd0);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b exp 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (dut_stat !== 22'd0) begin
      errors++; $display("FAIL reset_hold got %h exp %h", dut_stat, 22'd0);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [3:0] vals [7] = '{4'd5, 4'd9, 4'd2, 4'd9, 4'd0, 4'd0, 4'd0};
    logic       vld  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [21:0] fin = {4'd9, 4'd2, 8'd25, 4'd4, 1'b1, 1'b0};
    logic exp_rdy;
    exp_t e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_valid = vld[i]; in_data = vals[i]; #1;
      exp_rdy = (m_acc < 15);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL b2b_ready cyc %0d got %b exp %b", i, in_ready, exp_rdy);
      end
      if (vld[i] && exp_rdy) model_accept(vals[i]);
      @(posedge clk); #1;
      while (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
        e = exp_q.pop_front(); checks++;
        if (dut_stat !== e.stat) begin
          errors++; $display("FAIL b2b_stats cyc %0d got %h exp %h", i, dut_stat, e.stat);
        end
      end
    end
    checks++;
    if (dut_stat !== fin) begin
      errors++; $display("FAIL b2b_final got %h exp %h", dut_stat, fin);
    end
  endtask

  task automatic test_single();
    logic [3:0] vals [3] = '{4'd7, 4'd0, 4'd0};
    logic       vld  [3] = '{1'b1, 1'b0, 1'b0};
    logic exp_rdy;
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = vld[i]; in_data = vals[i]; #1;
      exp_rdy = (m_acc < 15);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL single_ready cyc %0d got %b exp %b", i, in_ready, exp_rdy);
      end
      if (vld[i] && exp_rdy) model_accept(vals[i]);
      @(posedge clk); #1;
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL single_early_valid got %b exp 0", out_valid);
        end
      end
      while (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
        e = exp_q.pop_front(); checks++;
        if (dut_stat !== e.stat) begin
          errors++; $display("FAIL single_stats cyc %0d got %h exp %h", i, dut_stat, e.stat);
        end
      end
    end
  endtask

  task automatic test_saturate();
    logic [21:0] fin = {4'd15, 4'd15, 8'd225, 4'd15, 1'b1, 1'b1};
    logic exp_rdy;
    logic v;
    int n_acc = 0;
    exp_t e;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      v = (i < 20);
      in_valid = v; in_data = 4'd15; #1;
      exp_rdy = (m_acc < 15);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL sat_ready cyc %0d got %b exp %b", i, in_ready, exp_rdy);
      end
      if (v && in_ready) n_acc++;
      if (v && exp_rdy) model_accept(4'd15);
      @(posedge clk); #1;
      while (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
        e = exp_q.pop_front(); checks++;
        if (dut_stat !== e.stat) begin
          errors++; $display("FAIL sat_stats cyc %0d got %h exp %h", i, dut_stat, e.stat);
        end
      end
    end
    checks++;
    if (n_acc != 15) begin
      errors++; $display("FAIL sat_accepts got %0d exp 15", n_acc);
    end
    checks++;
    if (dut_stat !== fin) begin
      errors++; $display("FAIL sat_final got %h exp %h", dut_stat, fin);
    end
  endtask

  task automatic test_clr();
    logic [21:0] after = {4'd10, 4'd10, 8'd10, 4'd1, 1'b1, 1'b0};
    exp_t e;
    do_reset();
    in_valid = 1'b1; in_data = 4'd6; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL clr_ready_pre got %b exp 1", in_ready);
    end
    model_accept(4'd6);
    @(posedge clk); #1;
    // 6 is in flight; clr together with an offered 3 discards both.
    in_data = 4'd3; clr = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL clr_ready_during got %b exp 0", in_ready);
    end
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (dut_stat !== 22'd0) begin
      errors++; $display("FAIL clr_stats got %h exp %h", dut_stat, 22'd0);
    end
    clr = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_stat !== 22'd0) begin
      errors++; $display("FAIL clr_no_ghost got %h exp %h", dut_stat, 22'd0);
    end
    in_valid = 1'b1; in_data = 4'd10; #1;
    model_accept(4'd10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      while (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
        e = exp_q.pop_front(); checks++;
        if (dut_stat !== e.stat) begin
          errors++; $display("FAIL clr_restart got %h exp %h", dut_stat, e.stat);
        end
      end
    end
    checks++;
    if (dut_stat !== after) begin
      errors++; $display("FAIL clr_after got %h exp %h", dut_stat, after);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] pre [2] = '{4'd8, 4'd3};
    logic [21:0] fin = {4'd4, 4'd4, 8'd4, 4'd1, 1'b1, 1'b0};
    exp_t e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = pre[i]; #1;
      model_accept(pre[i]);
      @(posedge clk); #1;
      while (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
        e = exp_q.pop_front(); checks++;
        if (dut_stat !== e.stat) begin
          errors++; $display("FAIL arst_pre got %h exp %h", dut_stat, e.stat);
        end
      end
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_stat !== 22'd0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL arst_immediate got %h/%b exp %h/0", dut_stat, in_ready, 22'd0);
    end
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dut_stat !== 22'd0) begin
      errors++; $display("FAIL arst_no_partial got %h exp %h", dut_stat, 22'd0);
    end
    in_valid = 1'b1; in_data = 4'd4; #1;
    model_accept(4'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      while (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
        e = exp_q.pop_front(); checks++;
        if (dut_stat !== e.stat) begin
          errors++; $display("FAIL arst_after got %h exp %h", dut_stat, e.stat);
        end
      end
    end
    checks++;
    if (dut_stat !== fin) begin
      errors++; $display("FAIL arst_final got %h exp %h", dut_stat, fin);
    end
  endtask

  task automatic test_gapped();
    logic [3:0] vals [7] = '{4'd1, 4'd0, 4'd12, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       vld  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [21:0] fin = {4'd12, 4'd1, 8'd13, 4'd2, 1'b1, 1'b0};
    logic exp_rdy;
    exp_t e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_valid = vld[i]; in_data = vals[i]; #1;
      exp_rdy = (m_acc < 15);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL gap_ready cyc %0d got %b exp %b", i, in_ready, exp_rdy);
      end
      if (vld[i] && exp_rdy) model_accept(vals[i]);
      @(posedge clk); #1;
      while (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
        e = exp_q.pop_front(); checks++;
        if (dut_stat !== e.stat) begin
          errors++; $display("FAIL gap_stats cyc %0d got %h exp %h", i, dut_stat, e.stat);
        end
      end
    end
    checks++;
    if (dut_stat !== fin) begin
      errors++; $display("FAIL gap_final got %h exp %h", dut_stat, fin);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL gap_drain got %0d pending exp 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    test_reset();
    test_back_to_back();
    test_single();
    test_saturate();
    test_clr();
    test_async_reset();
    test_gapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
